// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target.
//  - i2c_state_e : protocol FSM states of the target
//  - I2C_ACK / I2C_NACK : SDA level of the acknowledge slot
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Input conditioning for one I2C line: a 2-FF synchroniser followed by a
// stability filter. The filtered output only follows the synchronised line
// once it has differed from the current filtered value for FILT_LEN
// consecutive clocks, so shorter glitches never reach the protocol logic.
// Ports:
//  aclk    system clock
//  aresetn asynchronous active-low reset (line idles high, so all stages reset to 1)
//  raw     asynchronous line from the pad
//  filt    synchronised, glitch-filtered line
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic raw,
  output logic filt
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          filt_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      filt_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      // cnt_reg counts consecutive cycles of disagreement; any agreement restarts it
      if (sync2_reg == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(FILT_LEN - 1)) begin
        filt_reg <= sync2_reg;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign filt = filt_reg;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS 8-bit registers at bus address TARGET_ADDR.
// Protocol: START, addr+W, pointer byte, data bytes (auto-increment, wraps)
// or START, addr+R, data bytes (auto-increment while the controller ACKs).
// SDA is driven open-drain through I2C_SDA_OE; SCL is never driven.
// Ports:
//  aclk, aresetn  system clock, asynchronous active-low reset
//  I2C_SCL_I/_SDA_I raw pad inputs (asynchronous)
//  I2C_SDA_OE     1 = pull SDA low
//  regs_o         flattened register bank, reg k at [8k+7:8k]
//  wr_stb_o       one-cycle pulse per register write, wr_idx_o gives the index
//  busy_o         set when our address is acknowledged, cleared by STOP
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         NUM_REGS    = 8,
  parameter int         FILT_LEN    = 3,
  localparam int        PW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  I2C_SCL_I,
  input  logic                  I2C_SDA_I,
  output logic                  I2C_SDA_OE,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic                  wr_stb_o,
  output logic [PW-1:0]         wr_idx_o,
  output logic                  busy_o
);

  logic scl_f, sda_f, scl_d_reg, sda_d_reg;
  logic scl_rise, scl_fall, start_evt, stop_evt;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .aclk(aclk), .aresetn(aresetn), .raw(I2C_SCL_I), .filt(scl_f)
  );
  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .aclk(aclk), .aresetn(aresetn), .raw(I2C_SDA_I), .filt(sda_f)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      scl_d_reg <= 1'b1;
      sda_d_reg <= 1'b1;
    end else begin
      scl_d_reg <= scl_f;
      sda_d_reg <= sda_f;
    end
  end

  // SCL must be high on both sides of the SDA edge, so an SDA change that
  // lands on the same filtered cycle as an SCL rise is not taken as START/STOP.
  assign scl_rise  = scl_f & ~scl_d_reg;
  assign scl_fall  = ~scl_f & scl_d_reg;
  assign start_evt = scl_f & scl_d_reg & sda_d_reg & ~sda_f;
  assign stop_evt  = scl_f & scl_d_reg & ~sda_d_reg & sda_f;

  i2c_state_e    state_reg, state_next;
  logic [2:0]    bitcnt_reg, bitcnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [PW-1:0] ptr_reg, ptr_next, ptr_inc;
  logic          oe_reg, oe_next;
  logic          slot_reg, slot_next;
  logic          rw_reg, rw_next;
  logic          busy_reg, busy_next;
  logic          wr_en, wr_stb_reg;
  logic [PW-1:0] wr_idx_reg;
  logic [7:0]    rx_byte, rd_cur, rd_inc;

  assign rx_byte = {shift_reg[6:0], sda_f};
  assign ptr_inc = (ptr_reg == PW'(NUM_REGS - 1)) ? '0 : ptr_reg + PW'(1);
  assign rd_cur  = regs_o[{ptr_reg, 3'b000} +: 8];
  assign rd_inc  = regs_o[{ptr_inc, 3'b000} +: 8];

  // slot_reg: in the *_ACK write states it marks that the ACK is already
  // being driven (first SCL fall drives it, second ends it); in RDATA it marks
  // that the freshly loaded byte's MSB still has to be put on the line.
  always_comb begin
    state_next  = state_reg;
    bitcnt_next = bitcnt_reg;
    shift_next  = shift_reg;
    ptr_next    = ptr_reg;
    oe_next     = oe_reg;
    slot_next   = slot_reg;
    rw_next     = rw_reg;
    busy_next   = busy_reg;
    wr_en       = 1'b0;
    if (start_evt) begin
      state_next  = ST_ADDR;
      bitcnt_next = '0;
      oe_next     = 1'b0;
      slot_next   = 1'b0;
    end else if (stop_evt) begin
      state_next = ST_IDLE;
      oe_next    = 1'b0;
      slot_next  = 1'b0;
      busy_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_ADDR: if (scl_rise) begin
          shift_next = rx_byte;
          if (bitcnt_reg == 3'd7) begin
            if (rx_byte[7:1] == TARGET_ADDR) begin
              state_next = ST_ADDR_ACK;
              rw_next    = rx_byte[0];
              busy_next  = 1'b1;
              slot_next  = 1'b0;
            end else begin
              state_next = ST_WAIT_STOP;
              busy_next  = 1'b0;
            end
          end else bitcnt_next = bitcnt_reg + 3'd1;
        end
        ST_ADDR_ACK: if (scl_fall) begin
          if (!slot_reg) begin
            oe_next   = ~I2C_ACK;
            slot_next = 1'b1;
          end else begin
            slot_next   = 1'b0;
            bitcnt_next = '0;
            if (rw_reg) begin
              state_next = ST_RDATA;
              shift_next = rd_cur;
              oe_next    = ~rd_cur[7];
            end else begin
              state_next = ST_PTR;
              oe_next    = 1'b0;
            end
          end
        end
        ST_PTR: if (scl_rise) begin
          shift_next = rx_byte;
          if (bitcnt_reg == 3'd7) begin
            if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
              ptr_next   = rx_byte[PW-1:0];
              state_next = ST_PTR_ACK;
              slot_next  = 1'b0;
            end else state_next = ST_WAIT_STOP;
          end else bitcnt_next = bitcnt_reg + 3'd1;
        end
        ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
          if (!slot_reg) begin
            oe_next   = ~I2C_ACK;
            slot_next = 1'b1;
          end else begin
            oe_next     = 1'b0;
            slot_next   = 1'b0;
            bitcnt_next = '0;
            state_next  = ST_WDATA;
          end
        end
        ST_WDATA: if (scl_rise) begin
          shift_next = rx_byte;
          if (bitcnt_reg == 3'd7) begin
            wr_en      = 1'b1;
            ptr_next   = ptr_inc;
            state_next = ST_WDATA_ACK;
            slot_next  = 1'b0;
          end else bitcnt_next = bitcnt_reg + 3'd1;
        end
        ST_RDATA: if (scl_fall) begin
          if (slot_reg) begin
            oe_next     = ~shift_reg[7];
            slot_next   = 1'b0;
            bitcnt_next = '0;
          end else if (bitcnt_reg == 3'd7) begin
            oe_next    = 1'b0;
            state_next = ST_RDATA_ACK;
          end else begin
            shift_next  = {shift_reg[6:0], 1'b0};
            oe_next     = ~shift_reg[6];
            bitcnt_next = bitcnt_reg + 3'd1;
          end
        end
        ST_RDATA_ACK: if (scl_rise) begin
          if (sda_f == I2C_NACK) begin
            state_next = ST_WAIT_STOP;
          end else begin
            ptr_next   = ptr_inc;
            shift_next = rd_inc;
            slot_next  = 1'b1;
            state_next = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg  <= ST_IDLE;
      bitcnt_reg <= '0;
      shift_reg  <= '0;
      ptr_reg    <= '0;
      oe_reg     <= 1'b0;
      slot_reg   <= 1'b0;
      rw_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      wr_stb_reg <= 1'b0;
      wr_idx_reg <= '0;
    end else begin
      state_reg  <= state_next;
      bitcnt_reg <= bitcnt_next;
      shift_reg  <= shift_next;
      ptr_reg    <= ptr_next;
      oe_reg     <= oe_next;
      slot_reg   <= slot_next;
      rw_reg     <= rw_next;
      busy_reg   <= busy_next;
      wr_stb_reg <= wr_en;
      if (wr_en) wr_idx_reg <= ptr_reg;
    end
  end

  // Register bank: every register must be visible on regs_o, so plain flops.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [7:0] q_reg;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                           q_reg <= '0;
        else if (wr_en && ptr_reg == PW'(gi))   q_reg <= rx_byte;
      end
      assign regs_o[8*gi +: 8] = q_reg;
    end
  endgenerate

  assign I2C_SDA_OE = oe_reg;
  assign wr_stb_o   = wr_stb_reg;
  assign wr_idx_o   = wr_idx_reg;
  assign busy_o     = busy_reg;

endmodule

// File: tb/tb_i2c_target_regs.sv
module tb_i2c_target_regs;

  localparam int         N     = 8;
  localparam int         Q     = 8;      // aclk cycles per quarter SCL period
  localparam logic [6:0] TADDR = 7'h50;

  logic aclk = 1'b0, aresetn = 1'b0;
  logic m_scl_low = 1'b0, m_sda_low = 1'b0, m_glitch = 1'b0;
  logic scl_line, sda_line, oe, wr_stb, busy;
  logic [8*N-1:0] regs_o;
  logic [2:0] wr_idx;

  // wired-AND bus with pull-ups: controller pulls via m_*_low, target via OE
  assign scl_line = ~m_scl_low;
  assign sda_line = ~((m_sda_low ^ m_glitch) | oe);

  i2c_target_regs #(.TARGET_ADDR(TADDR), .NUM_REGS(N), .FILT_LEN(3)) dut (
    .aclk(aclk), .aresetn(aresetn), .I2C_SCL_I(scl_line), .I2C_SDA_I(sda_line),
    .I2C_SDA_OE(oe), .regs_o(regs_o), .wr_stb_o(wr_stb), .wr_idx_o(wr_idx), .busy_o(busy)
  );

  initial forever #5 aclk = ~aclk;

  typedef struct { int idx; logic [7:0] data; } wr_t;

  int         errors = 0, checks = 0;
  logic [7:0] m_regs [N];
  int         m_ptr = 0;
  wr_t        wq[$];
  int         wq_rd = 0;
  int         stb_log[$];
  logic [7:0] rd_log[$];
  bit         forbid_oe = 1'b0;
  logic       oe_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8*N-1:0] pack_regs();
    logic [8*N-1:0] v;
    for (int k = 0; k < N; k++) v[8*k +: 8] = m_regs[k];
    return v;
  endfunction

  // per-cycle comparison against the model register file
  task automatic monitor();
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        for (int k = 0; k < N; k++) m_regs[k] = 8'h00;
        wq_rd   = wq.size();
        oe_prev = 1'b0;
      end else begin
        if (wr_stb) begin
          if (wq_rd >= wq.size()) begin
            chk("unexpected_wr_stb", 1'b1, 1'b0);
          end else begin
            chk("wr_idx", wr_idx, wq[wq_rd].idx);
            m_regs[wq[wq_rd].idx] = wq[wq_rd].data;
            wq_rd++;
          end
          stb_log.push_back(int'(wr_idx));
        end
        chk("regs_o", regs_o, pack_regs());
        if (forbid_oe) chk("oe_unaddressed", oe, 1'b0);
        chk("oe_rise_scl_high", oe & ~oe_prev & scl_line, 1'b0);
        oe_prev = oe;
      end
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge aclk);
    #1;
  endtask

  task automatic clock_bit(input logic drive_low, input logic glitch, output logic sampled);
    m_sda_low = drive_low; wait_q();
    m_scl_low = 1'b0;      wait_q();
    sampled = sda_line;
    if (glitch) begin
      m_glitch = 1'b1; @(posedge aclk); #1; m_glitch = 1'b0;
    end
    wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic start_c();
    m_sda_low = 1'b0; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic stop_c();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b0; wait_q(); wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] gmask, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(~b[i], gmask[i], s);
    clock_bit(1'b0, 1'b0, s);
    acked = ~s;
  endtask

  task automatic recv_byte(input logic give_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b0, 1'b0, s);
      b[i] = s;
    end
    clock_bit(give_ack, 1'b0, s);
  endtask

  task automatic addr_phase(input logic [6:0] a, input logic rw, output logic matched);
    logic ack;
    send_byte({a, rw}, 8'h00, ack);
    matched = (a == TADDR);
    chk("addr_ack", ack, matched);
    chk("busy_addr", busy, matched);
  endtask

  task automatic post_check();
    repeat (20) @(posedge aclk);
    #1;
    chk("busy_idle", busy, 1'b0);
    chk("oe_idle", oe, 1'b0);
    chk("wr_drained", wq_rd, wq.size());
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n,
                          input logic [7:0] d [4], input logic [7:0] gmask);
    logic m, ack;
    forbid_oe = (a != TADDR);
    start_c();
    addr_phase(a, 1'b0, m);
    if (m) begin
      send_byte(p, 8'h00, ack);
      chk("ptr_ack", ack, int'(p) < N);
      if (int'(p) < N) begin
        m_ptr = int'(p);
        for (int i = 0; i < n; i++) begin
          wq.push_back('{idx: m_ptr, data: d[i]});
          send_byte(d[i], (i == 0) ? gmask : 8'h00, ack);
          chk("data_ack", ack, 1'b1);
          m_ptr = (m_ptr + 1) % N;
        end
      end
    end
    stop_c();
    forbid_oe = 1'b0;
    post_check();
  endtask

  task automatic do_read(input logic [6:0] a, input logic set_ptr, input logic [7:0] p, input int n);
    logic m, ack;
    logic [7:0] b;
    rd_log.delete();
    forbid_oe = (a != TADDR);
    start_c();
    m = 1'b1;
    if (set_ptr) begin
      addr_phase(a, 1'b0, m);
      if (m) begin
        send_byte(p, 8'h00, ack);
        chk("ptr_ack", ack, int'(p) < N);
        if (int'(p) < N) m_ptr = int'(p);
        start_c();
      end
    end
    if (m) begin
      addr_phase(a, 1'b1, m);
      if (m) begin
        for (int i = 0; i < n; i++) begin
          logic [7:0] exp;
          exp = m_regs[m_ptr];
          recv_byte(i < n - 1, b);
          chk("rd_data", b, exp);
          rd_log.push_back(b);
          if (i < n - 1) m_ptr = (m_ptr + 1) % N;
        end
      end
    end
    stop_c();
    forbid_oe = 1'b0;
    post_check();
  endtask

  initial begin
    fork
      monitor();
      begin
        logic s;
        int   nstb;
        for (int k = 0; k < N; k++) m_regs[k] = 8'h00;
        repeat (5) @(posedge aclk);
        #2 aresetn = 1'b1;
        repeat (5) @(posedge aclk);
        #1;
        chk("reset_oe", oe, 1'b0);
        chk("reset_regs", regs_o, '0);
        chk("reset_stb", wr_stb, 1'b0);
        chk("reset_idx", wr_idx, 3'd0);
        chk("reset_busy", busy, 1'b0);

        // 1: pointer 2, two data bytes
        do_write(TADDR, 8'h02, 2, '{8'hA5, 8'h3C, 8'h00, 8'h00}, 8'h00);
        chk("t1_reg2", regs_o[23:16], 8'hA5);
        chk("t1_reg3", regs_o[31:24], 8'h3C);
        chk("t1_nstb", stb_log.size(), 2);
        if (stb_log.size() == 2) begin
          chk("t1_idx0", stb_log[0], 2);
          chk("t1_idx1", stb_log[1], 3);
        end

        // 2: pointer write, repeated START, read two bytes
        do_read(TADDR, 1'b1, 8'h02, 2);
        chk("t2_n", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
          chk("t2_b0", rd_log[0], 8'hA5);
          chk("t2_b1", rd_log[1], 8'h3C);
        end

        // 3: foreign address
        do_write(7'h51, 8'h02, 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 8'h00);
        chk("t3_reg2", regs_o[23:16], 8'hA5);

        // 4: wrap at the top, then an out-of-range pointer
        do_write(TADDR, 8'(N - 1), 2, '{8'h11, 8'h22, 8'h00, 8'h00}, 8'h00);
        chk("t4_reg7", regs_o[63:56], 8'h11);
        chk("t4_reg0", regs_o[7:0], 8'h22);
        nstb = stb_log.size();
        do_write(TADDR, 8'(N), 1, '{8'h99, 8'h00, 8'h00, 8'h00}, 8'h00);
        chk("t4_nowrite", stb_log.size(), nstb);

        // 6: one-cycle SDA glitches while SCL is high, on a 1 bit and a 0 bit
        do_write(TADDR, 8'h04, 2, '{8'hC3, 8'h5A, 8'h00, 8'h00}, 8'b1010_0000);
        chk("t6_reg4", regs_o[39:32], 8'hC3);
        chk("t6_reg5", regs_o[47:40], 8'h5A);

        // 5a: STOP after four data bits
        nstb = stb_log.size();
        start_c();
        addr_phase(TADDR, 1'b0, s);
        send_byte(8'h06, 8'h00, s);
        chk("t5_ptr_ack", s, 1'b1);
        m_ptr = 6;
        for (int i = 0; i < 4; i++) clock_bit(i[0], 1'b0, s);
        stop_c();
        post_check();
        chk("t5_nowrite", stb_log.size(), nstb);

        // 5b: reset while the target drives a 0 data bit (0xA5, bit 6)
        start_c();
        addr_phase(TADDR, 1'b0, s);
        send_byte(8'h02, 8'h00, s);
        start_c();
        addr_phase(TADDR, 1'b1, s);
        clock_bit(1'b0, 1'b0, s);
        chk("t5_rd_bit7", s, 1'b1);
        m_sda_low = 1'b0; wait_q();
        m_scl_low = 1'b0; wait_q();
        chk("t5_rd_drive", oe, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        chk("t5_rst_oe", oe, 1'b0);
        chk("t5_rst_regs", regs_o, '0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_stb", wr_stb, 1'b0);
        chk("t5_rst_idx", wr_idx, 3'd0);
        m_scl_low = 1'b0; m_sda_low = 1'b0; m_ptr = 0;
        repeat (4) @(posedge aclk);
        #2 aresetn = 1'b1;
        repeat (10) @(posedge aclk);
        #1;

        // randomized transactions against the model
        for (int it = 0; it < 10; it++) begin
          int         kind, n;
          logic [7:0] d [4];
          logic [7:0] p;
          kind = $urandom_range(0, 3);
          n    = $urandom_range(1, 3);
          p    = 8'($urandom_range(0, N - 1));
          for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
          case (kind)
            0: do_write(TADDR, p, n, d, 8'h00);
            1: do_read(TADDR, 1'b1, p, n);
            2: do_read(TADDR, 1'b0, p, n);
            default: begin
              if ($urandom_range(0, 1) == 1)
                do_write(TADDR ^ 7'($urandom_range(1, 127)), p, n, d, 8'h00);
              else
                do_write(TADDR, 8'($urandom_range(N, 255)), n, d, 8'h00);
            end
          endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join_any
  end

endmodule
